// File: rtl/snn_run_controller.sv
// Run sequencer for one SNN inference: latches the run length and batch, then per timestep
// fetches the input spike word from pattern memory and handshakes one neuron-array update.
module snn_run_controller #(
  parameter int NUM_INPUTS     = 32,
  parameter int PAT_ADDR_BITS  = 8,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         Local_Reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [31:0]                  sim_time,
  input  logic [5:0]                   batch_sel,
  output logic                         pat_mem_rd_en,
  output logic [6+PAT_ADDR_BITS-1:0]   pat_mem_addr,
  input  logic [NUM_INPUTS-1:0]        pat_mem_rdata,
  output logic [NUM_INPUTS-1:0]        spike_in_vec,
  output logic                         counters_clear,
  output logic                         step_en,
  input  logic                         step_ack,
  output logic [31:0]                  timestep,
  output logic                         network_busy,
  output logic                         done,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_STEP   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [31:0]             r_sim_time;
  logic [5:0]              r_batch;
  logic [31:0]             r_t;
  logic [NUM_INPUTS-1:0]   r_spikes;
  logic [2:0]              r_lat_cnt;
  logic                    r_step_en;
  logic                    r_busy;
  logic                    r_done;

  logic [31:0]             w_t_next;
  logic                    w_last_step;
  logic                    w_lat_hit;
  logic                    w_accept;
  logic                    w_kill;

  assign w_t_next    = r_t + 32'd1;
  assign w_last_step = (w_t_next == r_sim_time);
  assign w_lat_hit   = (r_lat_cnt == 3'(MEM_RD_LATENCY));
  // abort beats start in IDLE, and beats every transition once a run is active
  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  assign w_kill      = (r_state != S_IDLE) && abort;

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_kill) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) w_next = S_CLEAR;
        S_CLEAR:  w_next = (r_sim_time == 32'd0) ? S_FINISH : S_FETCH;
        S_FETCH:  w_next = S_WAIT;
        S_WAIT:   if (w_lat_hit) w_next = S_STEP;
        S_STEP:   if (step_ack) w_next = w_last_step ? S_FINISH : S_FETCH;
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_sim_time <= '0;
      r_batch    <= '0;
      r_t        <= '0;
      r_spikes   <= '0;
      r_lat_cnt  <= '0;
      r_step_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_kill) begin
      // timestep and spikes deliberately hold so software can see where the run stopped
      r_step_en <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sim_time <= sim_time;
            r_batch    <= batch_sel;
            r_t        <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: r_lat_cnt <= 3'd1;
        S_WAIT: begin
          if (w_lat_hit) begin
            r_spikes  <= pat_mem_rdata;
            r_step_en <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_STEP: begin
          if (step_ack) begin
            r_step_en <= 1'b0;
            r_t       <= w_t_next;
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pat_mem_rd_en  = (r_state == S_FETCH);
  assign counters_clear = (r_state == S_CLEAR);
  assign pat_mem_addr   = {r_batch, r_t[PAT_ADDR_BITS-1:0]};
  assign spike_in_vec   = r_spikes;
  assign step_en        = r_step_en;
  assign timestep       = r_t;
  assign network_busy   = r_busy;
  assign done           = r_done;
  assign dbg_state      = r_state;

endmodule
